// File: rtl/ahb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_decode_ctrl
// Purpose  : Address decoder and data-phase response controller for a
//            two-slave AHB-Lite subsystem.
//            - Decodes HADDR in the address phase to HSEL_1 and HSEL_2.
//            - Carries the slave choice into the data phase and drives the
//              response mux select.
//            - Contains the default slave, which answers unmapped accesses
//              with a two-cycle ERROR response.
//            - Merges the mux outputs into the final HRDATA, HRESP and
//              HREADY.
// Ports    : HCLK, HRESETn         clock and asynchronous active-low reset
//            HADDR, HTRANS         master address phase
//            HSEL_1, HSEL_2        combinational slave selects
//            MUX_SEL               data-phase response select (0=S1, 1=S2)
//            HRDATA_mux, HRESP_mux, HREADY_mux
//                                  response from the slave mux
//            HRDATA, HRESP, HREADY final bus response (HREADY fed back)
//            ERR_CLR, ERR_CNT      saturating default-slave error counter
// Revision : 1.0  initial release
// ============================================================================
module ahb_decode_ctrl #(
   parameter logic [31:0] S1_BASE     = 32'h0000_0000,
   parameter logic [31:0] S2_BASE     = 32'h0000_1000,
   parameter int          REGION_BITS = 12,
   parameter int          CNT_WIDTH   = 8,
   parameter int          DATAWIDTH   = 32
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   output logic                 HSEL_1,
   output logic                 HSEL_2,
   output logic                 MUX_SEL,
   input  logic [DATAWIDTH-1:0] HRDATA_mux,
   input  logic                 HRESP_mux,
   input  logic                 HREADY_mux,
   output logic [DATAWIDTH-1:0] HRDATA,
   output logic                 HRESP,
   output logic                 HREADY,
   input  logic                 ERR_CLR,
   output logic [CNT_WIDTH-1:0] ERR_CNT
);

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Owner of the current data phase.
   typedef enum logic [1:0] {
      DSEL_NONE = 2'd0,
      DSEL_S1   = 2'd1,
      DSEL_S2   = 2'd2,
      DSEL_DEF  = 2'd3
   } dsel_t;

   // Default-slave response sequencer.
   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_ERR1 = 2'd1,
      D_ERR2 = 2'd2
   } dstate_t;

   dsel_t                dsel_q,    dsel_d;
   dstate_t              state_q,   state_d;
   logic                 mux_sel_q, mux_sel_d;
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic hit1;
   logic hit2;
   logic xfer;        // NONSEQ or SEQ in the address phase
   logic go_err;      // unmapped transfer accepted this cycle

   // ------------------------------------------------------------------------
   // Address decode. Slave 1 wins if the two regions overlap, so at most one
   // select is ever high. HTRANS is deliberately not used here.
   // ------------------------------------------------------------------------
   always_comb begin
      hit1 = (HADDR[31:REGION_BITS] == S1_BASE[31:REGION_BITS]);
      hit2 = (HADDR[31:REGION_BITS] == S2_BASE[31:REGION_BITS]) && !hit1;
      xfer = HTRANS[1];
   end

   assign HSEL_1 = hit1;
   assign HSEL_2 = hit2;

   // ------------------------------------------------------------------------
   // Output merge from the data-phase owner.
   // ------------------------------------------------------------------------
   always_comb begin
      HRDATA = '0;
      HRESP  = HRESP_OKAY;
      HREADY = 1'b1;
      case (dsel_q)
         DSEL_S1, DSEL_S2: begin
            HRDATA = HRDATA_mux;
            HRESP  = HRESP_mux;
            HREADY = HREADY_mux;
         end
         DSEL_DEF: begin
            // D_IDLE cannot coexist with DSEL_DEF; it falls back to OKAY.
            case (state_q)
               D_ERR1: begin
                  HRESP  = HRESP_ERROR;
                  HREADY = 1'b0;
               end
               D_ERR2: begin
                  HRESP  = HRESP_ERROR;
                  HREADY = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Everything advances only when the bus is ready, so a
   // slave wait state freezes dsel, MUX_SEL and the default slave alike.
   // ------------------------------------------------------------------------
   always_comb begin
      dsel_d    = dsel_q;
      mux_sel_d = mux_sel_q;
      state_d   = state_q;
      err_cnt_d = err_cnt_q;

      go_err = HREADY && xfer && !hit1 && !hit2;

      if (HREADY) begin
         if (!xfer) begin
            dsel_d = DSEL_NONE;
         end else if (hit1) begin
            dsel_d = DSEL_S1;
         end else if (hit2) begin
            dsel_d = DSEL_S2;
         end else begin
            dsel_d = DSEL_DEF;
         end

         // MUX_SEL only changes for a real slave phase; NONE and DEF phases
         // never route through the mux, so the previous select is kept.
         if (xfer && (hit1 || hit2)) begin
            mux_sel_d = hit2;
         end
      end

      case (state_q)
         D_IDLE:  if (go_err) state_d = D_ERR1;
         D_ERR1:  state_d = D_ERR2;
         D_ERR2:  state_d = go_err ? D_ERR1 : D_IDLE;
         default: state_d = D_IDLE;
      endcase

      if (ERR_CLR) begin
         err_cnt_d = '0;
      end else if (go_err && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // State registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel_q    <= DSEL_NONE;
         state_q   <= D_IDLE;
         mux_sel_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         dsel_q    <= dsel_d;
         state_q   <= state_d;
         mux_sel_q <= mux_sel_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign MUX_SEL = mux_sel_q;
   assign ERR_CNT = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_decode_ctrl
// Purpose  : Self-checking bench for ahb_decode_ctrl. A cycle table drives
//            the decode, slave pass-through, wait-state and error flows;
//            hand sequences cover asynchronous reset during an ERROR
//            response and error-counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_decode_ctrl;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = T_IDLE;
   logic        HSEL_1, HSEL_2, MUX_SEL;
   logic [31:0] HRDATA_mux = '0;
   logic        HRESP_mux = 1'b0;
   logic        HREADY_mux = 1'b1;
   logic [31:0] HRDATA;
   logic        HRESP, HREADY;
   logic        ERR_CLR = 1'b0;
   logic [7:0]  ERR_CNT;

   int total = 0;
   int bad   = 0;

   always #5 HCLK = ~HCLK;

   ahb_decode_ctrl dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HADDR      (HADDR),
      .HTRANS     (HTRANS),
      .HSEL_1     (HSEL_1),
      .HSEL_2     (HSEL_2),
      .MUX_SEL    (MUX_SEL),
      .HRDATA_mux (HRDATA_mux),
      .HRESP_mux  (HRESP_mux),
      .HREADY_mux (HREADY_mux),
      .HRDATA     (HRDATA),
      .HRESP      (HRESP),
      .HREADY     (HREADY),
      .ERR_CLR    (ERR_CLR),
      .ERR_CNT    (ERR_CNT)
   );

   typedef struct {
      logic [1:0]  htrans;
      logic [31:0] haddr;
      logic [31:0] rdm;
      logic        respm;
      logic        rdym;
      logic        clr;
      logic        e_hsel1;
      logic        e_hsel2;
      logic        e_muxsel;
      logic [31:0] e_rdata;
      logic        e_resp;
      logic        e_rdy;
      logic [7:0]  e_cnt;
   } vec_t;

   localparam int NV = 17;
   vec_t v [NV];

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d actual=0x%08h required=0x%08h",
                  name, row, act, exp);
      end
   endtask

   task automatic chk_all(input int row, input vec_t e);
      chk("HSEL_1",  row, {31'd0, HSEL_1},  {31'd0, e.e_hsel1});
      chk("HSEL_2",  row, {31'd0, HSEL_2},  {31'd0, e.e_hsel2});
      chk("MUX_SEL", row, {31'd0, MUX_SEL}, {31'd0, e.e_muxsel});
      chk("HRDATA",  row, HRDATA,           e.e_rdata);
      chk("HRESP",   row, {31'd0, HRESP},   {31'd0, e.e_resp});
      chk("HREADY",  row, {31'd0, HREADY},  {31'd0, e.e_rdy});
      chk("ERR_CNT", row, {24'd0, ERR_CNT}, {24'd0, e.e_cnt});
   endtask

   initial begin
      // htrans, haddr, rdata_mux, resp_mux, ready_mux, clr |
      //   hsel1, hsel2, mux_sel, hrdata, hresp, hready, err_cnt
      // Idle after reset: zero-wait OKAY, HSEL_1 still follows address 0.
      v[0]  = '{T_IDLE,   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd0};
      // Address phase to slave 1; data phase still NONE, mux data blocked.
      v[1]  = '{T_NONSEQ, 32'h0000_0010, 32'hDEAD_0000, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd0};
      // Back-to-back address to slave 2; slave 1 data passes through.
      v[2]  = '{T_NONSEQ, 32'h0000_1020, 32'hAAAA_0001, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 1'b1, 8'd0};
      // Slave 2 data phase; next address again slave 2.
      v[3]  = '{T_NONSEQ, 32'h0000_1040, 32'hBBBB_0002, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b1, 8'd0};
      // Three slave-2 wait states while slave-1 address is held pending.
      v[4]  = '{T_NONSEQ, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 8'd0};
      v[5]  = v[4];
      v[6]  = v[4];
      // Slave 2 ready; the pending slave-1 address is sampled now.
      v[7]  = '{T_NONSEQ, 32'h0000_0020, 32'hCCCC_0003, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b1, 32'hCCCC_0003, 1'b0, 1'b1, 8'd0};
      // Slave-1 data phase; unmapped address presented.
      v[8]  = '{T_NONSEQ, 32'h0000_5000, 32'hDDDD_0004, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, 32'hDDDD_0004, 1'b0, 1'b1, 8'd0};
      // ERR1 then ERR2; mux inputs must not leak through.
      v[9]  = '{T_IDLE,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'd1};
      v[10] = '{T_IDLE,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'd1};
      // Following IDLE is OKAY; first of two unmapped transfers presented.
      v[11] = '{T_NONSEQ, 32'h0000_5000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd1};
      v[12] = '{T_NONSEQ, 32'h0000_6000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'd2};
      // ERR2 samples the second unmapped transfer; clear wins over increment.
      v[13] = '{T_NONSEQ, 32'h0000_6000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'd2};
      v[14] = '{T_IDLE,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'd0};
      v[15] = '{T_IDLE,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'd0};
      v[16] = '{T_IDLE,   32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'd0};

      // Reset held across a few edges, released away from the clock edge.
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;

      // Inputs change on the falling edge; outputs checked 1 time unit later.
      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge HCLK);
         HTRANS     = v[i].htrans;
         HADDR      = v[i].haddr;
         HRDATA_mux = v[i].rdm;
         HRESP_mux  = v[i].respm;
         HREADY_mux = v[i].rdym;
         ERR_CLR    = v[i].clr;
         #1;
         chk_all(i, v[i]);
      end

      // ---- Asynchronous reset in the middle of D_ERR1 ----
      @(negedge HCLK);
      HTRANS     = T_NONSEQ;
      HADDR      = 32'h0000_7000;
      HRDATA_mux = 32'hFFFF_FFFF;
      @(negedge HCLK);
      HTRANS = T_IDLE;
      HADDR  = 32'h0000_0000;
      #1;
      chk("err1_hready", 100, {31'd0, HREADY}, 32'd0);
      chk("err1_hresp",  100, {31'd0, HRESP},  32'd1);
      chk("err1_cnt",    100, {24'd0, ERR_CNT}, 32'd1);
      HRESETn = 1'b0;
      #1;
      chk("rst_hready",  101, {31'd0, HREADY},  32'd1);
      chk("rst_hresp",   101, {31'd0, HRESP},   32'd0);
      chk("rst_hrdata",  101, HRDATA,           32'd0);
      chk("rst_cnt",     101, {24'd0, ERR_CNT}, 32'd0);
      chk("rst_muxsel",  101, {31'd0, MUX_SEL}, 32'd0);
      HADDR = 32'h0000_1000;
      #1;
      chk("rst_hsel2",   102, {31'd0, HSEL_2},  32'd1);
      chk("rst_hsel1",   102, {31'd0, HSEL_1},  32'd0);

      // Release reset, then a NONSEQ to slave 1 completes OKAY.
      @(negedge HCLK);
      HRESETn    = 1'b1;
      HTRANS     = T_NONSEQ;
      HADDR      = 32'h0000_0000;
      HRDATA_mux = 32'h5555_AAAA;
      HRESP_mux  = 1'b0;
      HREADY_mux = 1'b1;
      @(negedge HCLK);
      HTRANS = T_IDLE;
      #1;
      chk("post_hrdata", 103, HRDATA,           32'h5555_AAAA);
      chk("post_hresp",  103, {31'd0, HRESP},   32'd0);
      chk("post_hready", 103, {31'd0, HREADY},  32'd1);
      chk("post_muxsel", 103, {31'd0, MUX_SEL}, 32'd0);

      // ---- Counter saturation: 300 back-to-back unmapped transfers ----
      @(negedge HCLK);
      HTRANS = T_NONSEQ;
      HADDR  = 32'h0000_5000;
      repeat (600) @(negedge HCLK);
      #1;
      chk("sat_cnt",     104, {24'd0, ERR_CNT}, 32'd255);
      @(negedge HCLK);
      HTRANS = T_IDLE;
      #1;
      chk("sat_hold",    105, {24'd0, ERR_CNT}, 32'd255);
      repeat (3) @(negedge HCLK);
      #1;
      chk("sat_idle",    106, {31'd0, HRESP},   32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
